// File: rtl/ultrasonic_ranger_ctrl_pkg.sv
// Shared types and constants for the ultrasonic ranger controller.
// Optional build macro: US_NEAR_HYST_EN (two-sample hysteresis on the near flag).
package ultrasonic_pkg;

  // Measurement sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    DONE
  } state_t;

  // Clocks per microsecond for a given system clock.
  function automatic int cyc_per_us_f(input int clk_hz);
    return clk_hz / 1_000_000;
  endfunction

  // Bits needed to hold any value in 0..max_val (never less than one).
  function automatic int cnt_width(input int max_val);
    if (max_val < 2) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

  // Nominal operating point: 50 MHz clock, HC-SR04 timing.
  localparam int DEF_CLK_HZ    = 50_000_000;
  localparam int DEF_TRIG_US   = 10;
  localparam int DEF_PERIOD_MS = 60;
  localparam int DEF_US_PER_CM = 58;

  // Derived cycle constants at the nominal operating point.
  localparam int CYC_PER_US = cyc_per_us_f(DEF_CLK_HZ);
  localparam int TRIG_CYC   = DEF_TRIG_US * CYC_PER_US;
  localparam int CYC_PER_CM = DEF_US_PER_CM * CYC_PER_US;
  localparam int TIMEOUT_US = 30_000;
  localparam int PERIOD_US  = DEF_PERIOD_MS * 1000;

endpackage

// File: rtl/ultrasonic_ranger_ctrl_us_tick_gen.sv
// Microsecond prescaler: us_tick pulses once every DIV clocks, phase0 marks
// the first clock of each microsecond. clr_n is a synchronous active-low clear
// that parks the prescaler at phase 0.
module us_tick_gen #(
  parameter int DIV = 50
) (
  input  logic clk,
  input  logic clr_n,
  output logic us_tick,
  output logic phase0
);
  import ultrasonic_pkg::*;

  localparam int PW = cnt_width(DIV - 1);

  logic [PW-1:0] presc_reg;

  // Free-running modulo-DIV count, restarted by clr_n.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      presc_reg <= '0;
    end else if (presc_reg == PW'(DIV - 1)) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + PW'(1);
    end
  end

  assign us_tick = (presc_reg == PW'(DIV - 1));
  assign phase0  = (presc_reg == '0);

endmodule

// File: rtl/ultrasonic_ranger_ctrl.sv
// HC-SR04 style ranger: periodic trigger, echo timing, divider-free cm
// conversion, valid/timeout strobes and a registered near flag.
// Optional build macro: US_NEAR_HYST_EN (two-sample hysteresis on near).
module ultrasonic_ranger_ctrl #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TRIG_US    = 10,
  parameter int PERIOD_MS  = 60,
  parameter int TIMEOUT_US = 30_000,
  parameter int US_PER_CM  = 58,
  parameter int DIST_W     = 16,
  parameter int NEAR_CM    = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              echo,
  output logic              trig,
  output logic [DIST_W-1:0] distance,
  output logic              dist_valid,
  output logic              timeout,
  output logic              near,
  output logic              busy
);
  import ultrasonic_pkg::*;

  localparam int US_DIV       = cyc_per_us_f(CLK_HZ);
  localparam int TRIG_CLKS    = TRIG_US * US_DIV;
  localparam int CM_CLKS      = US_PER_CM * US_DIV;
  localparam int TMO_CLKS     = TIMEOUT_US * US_DIV;
  localparam int PERIOD_TICKS = PERIOD_MS * 1000;

  localparam int TW = cnt_width(TRIG_CLKS - 1);
  localparam int CW = cnt_width(CM_CLKS - 1);
  localparam int OW = cnt_width(TMO_CLKS - 1);
  localparam int PW = cnt_width(PERIOD_TICKS - 1);

  state_t            state_reg, state_next;
  logic [2:0]        echo_pipe_reg;
  logic              echo_sync, echo_prev, echo_rise, echo_fall;
  logic              us_tick, us_phase0;
  logic [PW-1:0]     period_reg;
  logic              trig_req;
  logic [TW-1:0]     trig_cnt_reg, trig_cnt_next;
  logic [OW-1:0]     tmo_cnt_reg, tmo_cnt_next;
  logic [CW-1:0]     cyc_cnt_reg, cyc_cnt_next;
  logic [DIST_W-1:0] cm_cnt_reg, cm_cnt_next;
  logic              dist_load, timeout_next;
  logic [DIST_W-1:0] distance_reg;
  logic              dist_valid_reg, timeout_reg, near_reg;
  logic              is_near;

  // Prescaler is held at phase 0 while disabled so the first trigger after
  // enable rises one clock later and later triggers land exactly one period on.
  us_tick_gen #(
    .DIV(US_DIV)
  ) u_tick (
    .clk    (clk),
    .clr_n  (rst_n & enable),
    .us_tick(us_tick),
    .phase0 (us_phase0)
  );

  // Echo synchronizer: [0] metastable stage, [1] synchronized, [2] previous.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      echo_pipe_reg <= '0;
    end else begin
      echo_pipe_reg <= {echo_pipe_reg[1:0], echo};
    end
  end

  assign echo_sync = echo_pipe_reg[1];
  assign echo_prev = echo_pipe_reg[2];
  assign echo_rise = echo_sync & ~echo_prev;
  assign echo_fall = ~echo_sync & echo_prev;

  // Measurement period in microseconds; cleared whenever disabled.
  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      period_reg <= '0;
    end else if (us_tick) begin
      if (period_reg == PW'(PERIOD_TICKS - 1)) begin
        period_reg <= '0;
      end else begin
        period_reg <= period_reg + PW'(1);
      end
    end
  end

  // One-clock request at the start of every period; ignored unless IDLE,
  // so an overrunning measurement simply drops it.
  assign trig_req = enable && (period_reg == '0) && us_phase0;

  // Next-state and counter logic. In MEASURE the count includes the cycle
  // that detects the fall, which makes the clock count equal the echo width.
  always_comb begin
    state_next    = state_reg;
    trig_cnt_next = trig_cnt_reg;
    tmo_cnt_next  = tmo_cnt_reg;
    cyc_cnt_next  = cyc_cnt_reg;
    cm_cnt_next   = cm_cnt_reg;
    dist_load     = 1'b0;
    timeout_next  = 1'b0;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (trig_req) begin
            state_next    = TRIG;
            trig_cnt_next = '0;
          end
        end
        TRIG: begin
          if (trig_cnt_reg == TW'(TRIG_CLKS - 1)) begin
            state_next   = WAIT_RISE;
            tmo_cnt_next = '0;
          end else begin
            trig_cnt_next = trig_cnt_reg + TW'(1);
          end
        end
        WAIT_RISE: begin
          if (echo_rise) begin
            state_next   = MEASURE;
            tmo_cnt_next = '0;
            cyc_cnt_next = '0;
            cm_cnt_next  = '0;
          end else if (tmo_cnt_reg == OW'(TMO_CLKS - 1)) begin
            state_next   = IDLE;
            timeout_next = 1'b1;
          end else begin
            tmo_cnt_next = tmo_cnt_reg + OW'(1);
          end
        end
        MEASURE: begin
          if (cyc_cnt_reg == CW'(CM_CLKS - 1)) begin
            cyc_cnt_next = '0;
            if (cm_cnt_reg != '1) begin
              cm_cnt_next = cm_cnt_reg + DIST_W'(1);
            end
          end else begin
            cyc_cnt_next = cyc_cnt_reg + CW'(1);
          end
          // A fall in the same cycle as the timeout still yields a result.
          if (echo_fall) begin
            state_next = DONE;
            dist_load  = 1'b1;
          end else if (tmo_cnt_reg == OW'(TMO_CLKS - 1)) begin
            state_next   = IDLE;
            timeout_next = 1'b1;
          end else begin
            tmo_cnt_next = tmo_cnt_reg + OW'(1);
          end
        end
        DONE: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State and working counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      trig_cnt_reg <= '0;
      tmo_cnt_reg  <= '0;
      cyc_cnt_reg  <= '0;
      cm_cnt_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      trig_cnt_reg <= trig_cnt_next;
      tmo_cnt_reg  <= tmo_cnt_next;
      cyc_cnt_reg  <= cyc_cnt_next;
      cm_cnt_reg   <= cm_cnt_next;
    end
  end

  assign is_near = (int'(cm_cnt_next) <= NEAR_CM);

`ifdef US_NEAR_HYST_EN
  logic is_far;
  logic near_run_reg, far_run_reg;

  assign is_far = (int'(cm_cnt_next) >= NEAR_CM + 2);

  // Result registers; near only flips after two agreeing valid samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      distance_reg   <= '0;
      dist_valid_reg <= 1'b0;
      timeout_reg    <= 1'b0;
      near_reg       <= 1'b0;
      near_run_reg   <= 1'b0;
      far_run_reg    <= 1'b0;
    end else begin
      dist_valid_reg <= dist_load;
      timeout_reg    <= timeout_next;
      if (dist_load) begin
        distance_reg <= cm_cnt_next;
        near_run_reg <= is_near;
        far_run_reg  <= is_far;
        if (is_near && near_run_reg) begin
          near_reg <= 1'b1;
        end else if (is_far && far_run_reg) begin
          near_reg <= 1'b0;
        end
      end
    end
  end
`else
  // Result registers; distance and near change together on each valid result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      distance_reg   <= '0;
      dist_valid_reg <= 1'b0;
      timeout_reg    <= 1'b0;
      near_reg       <= 1'b0;
    end else begin
      dist_valid_reg <= dist_load;
      timeout_reg    <= timeout_next;
      if (dist_load) begin
        distance_reg <= cm_cnt_next;
        near_reg     <= is_near;
      end
    end
  end
`endif

  assign trig       = (state_reg == TRIG);
  assign busy       = (state_reg != IDLE);
  assign distance   = distance_reg;
  assign dist_valid = dist_valid_reg;
  assign timeout    = timeout_reg;
  assign near       = near_reg;

endmodule

// File: tb/tb_ultrasonic_ranger_ctrl.sv
// Self-checking bench for ultrasonic_ranger_ctrl at a scaled-down operating
// point (2 MHz clock, 1 ms period, 200 us timeout, 2 us/cm, 6-bit distance).
// Honours US_NEAR_HYST_EN in its reference model.
module tb_ultrasonic_ranger_ctrl;

  localparam int CLK_HZ     = 2_000_000;
  localparam int TRIG_US    = 10;
  localparam int PERIOD_MS  = 1;
  localparam int TIMEOUT_US = 200;
  localparam int US_PER_CM  = 2;
  localparam int DIST_W     = 6;
  localparam int NEAR_CM    = 7;

  localparam int CPU         = CLK_HZ / 1_000_000;
  localparam int TRIG_CLKS   = TRIG_US * CPU;
  localparam int CM_CLKS     = US_PER_CM * CPU;
  localparam int TMO_CLKS    = TIMEOUT_US * CPU;
  localparam int PERIOD_CLKS = PERIOD_MS * 1000 * CPU;
  localparam int DMAX        = (1 << DIST_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic              echo;
  logic              trig;
  logic [DIST_W-1:0] distance;
  logic              dist_valid;
  logic              timeout;
  logic              near;
  logic              busy;

  int   checks    = 0;
  int   failures  = 0;
  int   cyc       = 0;
  int   dv_cnt    = 0;
  int   to_cnt    = 0;
  int   both_cnt  = 0;
  int   last_rise = 0;
  bit   rise_valid = 0;
  int   dv_dist   = 0;
  logic dv_near   = 1'b0;
  int   model_dist = 0;
  logic model_near = 1'b0;
  bit   hyst_near_q = 0;
  bit   hyst_far_q  = 0;

  ultrasonic_ranger_ctrl #(
    .CLK_HZ    (CLK_HZ),
    .TRIG_US   (TRIG_US),
    .PERIOD_MS (PERIOD_MS),
    .TIMEOUT_US(TIMEOUT_US),
    .US_PER_CM (US_PER_CM),
    .DIST_W    (DIST_W),
    .NEAR_CM   (NEAR_CM)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .echo      (echo),
    .trig      (trig),
    .distance  (distance),
    .dist_valid(dist_valid),
    .timeout   (timeout),
    .near      (near),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample outputs 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (dist_valid === 1'b1) begin
      dv_cnt++;
      dv_dist = int'(distance);
      dv_near = near;
    end
    if (timeout === 1'b1) to_cnt++;
    if (dist_valid === 1'b1 && timeout === 1'b1) both_cnt++;
  endtask

  // Reference: result from echo width in clocks, as stated for the sensor.
  task automatic model_sample(input int width);
    int d;
    d = width / CM_CLKS;
    if (d > DMAX) d = DMAX;
    model_dist = d;
`ifdef US_NEAR_HYST_EN
    if (d <= NEAR_CM && hyst_near_q) model_near = 1'b1;
    else if (d >= NEAR_CM + 2 && hyst_far_q) model_near = 1'b0;
    hyst_near_q = (d <= NEAR_CM);
    hyst_far_q  = (d >= NEAR_CM + 2);
`else
    model_near = (d <= NEAR_CM);
`endif
  endtask

  task automatic wait_trig();
    int n;
    n = 0;
    while (trig !== 1'b1 && n < 2 * PERIOD_CLKS) begin
      tick();
      n++;
    end
    chk("trig_rise", trig, 1);
    if (rise_valid) chk("trig_period", cyc - last_rise, PERIOD_CLKS);
    last_rise  = cyc;
    rise_valid = 1;
    n = 0;
    while (trig === 1'b1 && n < 4 * TRIG_CLKS) begin
      tick();
      n++;
    end
    chk("trig_width", n, TRIG_CLKS);
    chk("busy_wait", busy, 1);
  endtask

  // One measurement: echo starts dly clocks after trig falls and lasts
  // width clocks; width <= 0 means the echo never arrives.
  task automatic measure(input int dly, input int width);
    int n, dv0, to0;
    bit exp_valid;
    wait_trig();
    dv0 = dv_cnt;
    to0 = to_cnt;
    repeat (dly) tick();
    if (width <= 0) begin
      n = 0;
      while (to_cnt == to0 && n < 2 * TMO_CLKS) begin
        tick();
        n++;
      end
      chk("rise_timeout_lat", n + dly, TMO_CLKS);
    end else begin
      echo = 1'b1;
      repeat (width) tick();
      echo = 1'b0;
      repeat (8) tick();
    end
    exp_valid = (width > 0) && (width <= TMO_CLKS);
    if (exp_valid) model_sample(width);
    chk("dv_count", dv_cnt - dv0, exp_valid ? 1 : 0);
    chk("to_count", to_cnt - to0, exp_valid ? 0 : 1);
    if (exp_valid) begin
      chk("dv_distance", dv_dist, model_dist);
      chk("dv_near", dv_near, model_near);
    end
    chk("distance", distance, model_dist);
    chk("near", near, model_near);
    chk("busy_idle", busy, 0);
    $display("meas dly=%0d width=%0d distance=%0d near=%0d dv=%0d to=%0d",
             dly, width, distance, near, dv_cnt - dv0, to_cnt - to0);
  endtask

  initial begin
    int w, d;
    rst_n  = 1'b0;
    enable = 1'b0;
    echo   = 1'b0;
    repeat (3) tick();
    chk("rst_trig", trig, 0);
    chk("rst_distance", distance, 0);
    chk("rst_dist_valid", dist_valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_near", near, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_disabled_busy", busy, 0);
    enable = 1'b1;
    tick();
    chk("trig_first", trig, 1);
    chk("busy_first", busy, 1);

    // Directed widths: conversion, truncation, saturation, timeout edge.
    measure(0, 10 * CM_CLKS);
    measure(3, 7 * CM_CLKS);
    measure(1, 8 * CM_CLKS - 1);
    measure(2, 8 * CM_CLKS);
    measure(0, DMAX * CM_CLKS);
    measure(4, (DMAX + 1) * CM_CLKS);
    measure(0, TMO_CLKS);
    measure(0, TMO_CLKS + 1);

    // Near-flag sample sequence 6,20,6,6,8,9,9 cm.
    measure(1, 6 * CM_CLKS);
    measure(1, 20 * CM_CLKS);
    measure(1, 6 * CM_CLKS);
    measure(1, 6 * CM_CLKS);
    measure(1, 8 * CM_CLKS);
    measure(1, 9 * CM_CLKS);
    measure(1, 9 * CM_CLKS);

    // Randomized widths and echo delays.
    for (int i = 0; i < 6; i++) begin
      d = $urandom_range(0, 30);
      if ($urandom_range(0, 3) == 0) w = $urandom_range(1, TMO_CLKS + 20);
      else w = $urandom_range(1, 12 * CM_CLKS);
      measure(d, w);
    end

    // No echo at all: timeout from WAIT_RISE, next trigger one period on.
    measure(0, -1);
    measure(2, 10 * CM_CLKS);

    // Enable dropped in the middle of an echo.
    wait_trig();
    echo = 1'b1;
    repeat (30) tick();
    w = dv_cnt;
    d = to_cnt;
    enable = 1'b0;
    tick();
    chk("drop_busy", busy, 0);
    chk("drop_trig", trig, 0);
    repeat (20) tick();
    echo = 1'b0;
    repeat (10) tick();
    chk("drop_no_dv", dv_cnt - w, 0);
    chk("drop_no_to", to_cnt - d, 0);
    chk("drop_distance", distance, model_dist);
    chk("drop_near", near, model_near);
    $display("drop enable mid-measure distance=%0d near=%0d", distance, near);
    rise_valid = 0;
    enable = 1'b1;
    tick();
    chk("trig_reenable", trig, 1);
    measure(5, 9 * CM_CLKS);

    // Reset asserted mid-measurement.
    wait_trig();
    echo = 1'b1;
    repeat (30) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_trig", trig, 0);
    chk("midrst_distance", distance, 0);
    chk("midrst_dist_valid", dist_valid, 0);
    chk("midrst_timeout", timeout, 0);
    chk("midrst_near", near, 0);
    chk("midrst_busy", busy, 0);
    $display("reset mid-measure distance=%0d busy=%0d", distance, busy);
    echo = 1'b0;
    tick();
    model_dist  = 0;
    model_near  = 1'b0;
    hyst_near_q = 0;
    hyst_far_q  = 0;
    rise_valid  = 0;
    rst_n = 1'b1;
    measure(3, 5 * CM_CLKS + 2);
    measure(0, 30 * CM_CLKS);

    chk("valid_timeout_overlap", both_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
